rggen_apb_register_bridge: RTL and testbench

//  APB4 slave front end for a generated register block. Captures one APB transfer, drives the

---
 rtl/rggen_bridge_pkg.sv | 27 ++
 rtl/rggen_register_response_mux.sv | 43 ++++
 rtl/rggen_apb_register_bridge.sv | 157 +++++++++++++++
 tb/tb_rggen_apb_register_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_bridge_pkg.sv
// Shared types and helpers for the rggen bus bridges (APB now, AXI/AHB later).
package rggen_bridge_pkg;

    // Bridge protocol state: capture -> wait on registers -> answer the bus.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RESPOND = 2'd2
    } rggen_bridge_state_e;

    // Widest select vector the population-count helper accepts.
    localparam int ONEHOT_MAX_WIDTH = 256;

    // Saturating population count: 0 = none, 1 = exactly one, 2 = more than one.
    // Callers zero-extend their vector to ONEHOT_MAX_WIDTH with a size cast.
    function automatic logic [1:0] rggen_onehot_count(input logic [ONEHOT_MAX_WIDTH-1:0] bits);
        logic [1:0] count;
        count = 2'd0;
        for (int i = 0; i < ONEHOT_MAX_WIDTH; i++) begin
            if (bits[i] && (count != 2'd2)) begin
                count = count + 2'd1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/rggen_register_response_mux.sv
// Combinational reduction of per-register select/ready/read-data returns.
module rggen_register_response_mux
    import rggen_bridge_pkg::*;
#(
    parameter int REGISTERS  = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic [REGISTERS-1:0]            i_register_select,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
    output logic                            o_hit,
    output logic                            o_no_select,
    output logic                            o_multi_hit,
    output logic [DATA_WIDTH-1:0]           o_read_data
);

    logic [REGISTERS-1:0]  active;
    logic [DATA_WIDTH-1:0] masked_data [REGISTERS];
    logic [1:0]            select_count;

    // Each slot contributes its data only while it is both selected and ready.
    generate
        for (genvar gi = 0; gi < REGISTERS; gi++) begin : g_slot
            assign active[gi]      = i_register_select[gi] & i_register_ready[gi];
            assign masked_data[gi] = i_register_read_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                   & {DATA_WIDTH{active[gi]}};
        end
    endgenerate

    assign select_count = rggen_onehot_count(ONEHOT_MAX_WIDTH'(i_register_select));
    assign o_no_select  = (select_count == 2'd0);
    assign o_multi_hit  = (select_count == 2'd2);
    assign o_hit        = |active;

    // OR-reduce the masked slots into the returned read data.
    always_comb begin
        o_read_data = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            o_read_data = o_read_data | masked_data[i];
        end
    end

endmodule

// File: rtl/rggen_apb_register_bridge.sv
// APB4 slave front end: latches one transfer, drives the shared register
// request bus, and answers APB from the reduced register responses.
module rggen_apb_register_bridge
    import rggen_bridge_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERROR_STATUS   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_psel,
    input  logic                            i_penable,
    input  logic [ADDRESS_WIDTH-1:0]        i_paddr,
    input  logic                            i_pwrite,
    input  logic [DATA_WIDTH-1:0]           i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]         i_pstrb,
    output logic                            o_pready,
    output logic [DATA_WIDTH-1:0]           o_prdata,
    output logic                            o_pslverr,
    output logic                            o_register_request,
    output logic [ADDRESS_WIDTH-1:0]        o_register_address,
    output logic                            o_register_write,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    output logic [DATA_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]            i_register_select,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic ERROR_VALUE = (ERROR_STATUS != 0);

    rggen_bridge_state_e         state_q;
    logic [COUNTER_WIDTH-1:0]    count_q;
    logic                        pready_q;
    logic [DATA_WIDTH-1:0]       prdata_q;
    logic                        pslverr_q;
    logic                        request_q;
    logic [ADDRESS_WIDTH-1:0]    address_q;
    logic                        write_q;
    logic [DATA_WIDTH-1:0]       write_data_q;
    logic [DATA_WIDTH/8-1:0]     strobe_q;

    logic                        hit;
    logic                        no_select;
    logic                        multi_hit;
    logic [DATA_WIDTH-1:0]       mux_read_data;

    logic                        timeout;
    logic                        done_d;
    logic [DATA_WIDTH-1:0]       prdata_d;
    logic                        pslverr_d;

    rggen_register_response_mux #(
        .REGISTERS  (REGISTERS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_response_mux (
        .i_register_select    (i_register_select),
        .i_register_ready     (i_register_ready),
        .i_register_read_data (i_register_read_data),
        .o_hit                (hit),
        .o_no_select          (no_select),
        .o_multi_hit          (multi_hit),
        .o_read_data          (mux_read_data)
    );

    assign timeout = (TIMEOUT_CYCLES != 0) &&
                     (count_q == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));

    // Resolve the REQUEST outcome: multi-hit > no-select > hit > timeout (abort handled in FSM).
    always_comb begin
        done_d    = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (multi_hit || no_select) begin
            done_d    = 1'b1;
            pslverr_d = ERROR_VALUE;
        end else if (hit) begin
            done_d   = 1'b1;
            prdata_d = write_q ? '0 : mux_read_data;
        end else if (timeout) begin
            done_d    = 1'b1;
            pslverr_d = ERROR_VALUE;
        end
    end

    // Bridge FSM with registered APB response and register request fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
            request_q    <= 1'b0;
            address_q    <= '0;
            write_q      <= 1'b0;
            write_data_q <= '0;
            strobe_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    if (i_psel && !i_penable) begin
                        address_q    <= i_paddr;
                        write_q      <= i_pwrite;
                        write_data_q <= i_pwdata;
                        strobe_q     <= i_pwrite ? i_pstrb : '1;
                        request_q    <= 1'b1;
                        count_q      <= '0;
                        state_q      <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (!i_psel) begin
                        // Master walked away: drop the request without answering.
                        request_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (done_d) begin
                        request_q <= 1'b0;
                        pready_q  <= 1'b1;
                        prdata_q  <= prdata_d;
                        pslverr_q <= pslverr_d;
                        state_q   <= RESPOND;
                    end else if (count_q != '1) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                RESPOND: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_pready              = pready_q;
    assign o_prdata              = prdata_q;
    assign o_pslverr             = pslverr_q;
    assign o_register_request    = request_q;
    assign o_register_address    = address_q;
    assign o_register_write      = write_q;
    assign o_register_write_data = write_data_q;
    assign o_register_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_apb_register_bridge.sv
// Directed table-driven bench for the APB register bridge.
module tb_rggen_apb_register_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel_a = 1'b0;
    logic        psel_b = 1'b0;
    logic        penable = 1'b0;
    logic [15:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [1:0]  sel = '0;
    logic [1:0]  rdy = '0;
    logic [63:0] rdata = '0;

    logic        a_pready, a_pslverr, a_req, a_write;
    logic [31:0] a_prdata, a_wdata;
    logic [15:0] a_addr;
    logic [3:0]  a_strb;
    logic        b_pready, b_pslverr, b_req, b_write;
    logic [31:0] b_prdata, b_wdata;
    logic [15:0] b_addr;
    logic [3:0]  b_strb;

    logic        use_b = 1'b0;
    logic        c_pready, c_pslverr, c_req, c_write;
    logic [31:0] c_prdata, c_wdata;
    logic [15:0] c_addr;
    logic [3:0]  c_strb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // dut_a: errors enabled, 4-cycle timeout.
    rggen_apb_register_bridge #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .REGISTERS(2), .TIMEOUT_CYCLES(4), .ERROR_STATUS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_psel(psel_a), .i_penable(penable), .i_paddr(paddr),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(a_pready), .o_prdata(a_prdata), .o_pslverr(a_pslverr),
        .o_register_request(a_req), .o_register_address(a_addr), .o_register_write(a_write),
        .o_register_write_data(a_wdata), .o_register_strobe(a_strb),
        .i_register_select(sel), .i_register_ready(rdy), .i_register_read_data(rdata)
    );

    // dut_b: error reporting disabled, timeout disabled.
    rggen_apb_register_bridge #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .REGISTERS(2), .TIMEOUT_CYCLES(0), .ERROR_STATUS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_psel(psel_b), .i_penable(penable), .i_paddr(paddr),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(b_pready), .o_prdata(b_prdata), .o_pslverr(b_pslverr),
        .o_register_request(b_req), .o_register_address(b_addr), .o_register_write(b_write),
        .o_register_write_data(b_wdata), .o_register_strobe(b_strb),
        .i_register_select(sel), .i_register_ready(rdy), .i_register_read_data(rdata)
    );

    assign c_pready  = use_b ? b_pready  : a_pready;
    assign c_pslverr = use_b ? b_pslverr : a_pslverr;
    assign c_req     = use_b ? b_req     : a_req;
    assign c_write   = use_b ? b_write   : a_write;
    assign c_prdata  = use_b ? b_prdata  : a_prdata;
    assign c_wdata   = use_b ? b_wdata   : a_wdata;
    assign c_addr    = use_b ? b_addr    : a_addr;
    assign c_strb    = use_b ? b_strb    : a_strb;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  sel;
        int          delay;      // REQUEST cycles before ready rises
        logic [31:0] data0;
        logic [31:0] data1;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;  // edges from setup edge to pready
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pready"},  {31'd0, c_pready},  32'd0);
        check({tag, " prdata"},  c_prdata,           32'd0);
        check({tag, " pslverr"}, {31'd0, c_pslverr}, 32'd0);
        check({tag, " request"}, {31'd0, c_req},     32'd0);
        check({tag, " address"}, {16'd0, c_addr},    32'd0);
        check({tag, " write"},   {31'd0, c_write},   32'd0);
        check({tag, " wdata"},   c_wdata,            32'd0);
        check({tag, " strobe"},  {28'd0, c_strb},    32'd0);
    endtask

    task automatic do_xfer(input vec_t v, input logic on_b, input string tag);
        int  n;
        logic got;
        @(negedge clk);
        use_b   = on_b;
        psel_a  = !on_b;
        psel_b  = on_b;
        penable = 1'b0;
        paddr   = v.addr;
        pwrite  = v.write;
        pwdata  = v.wdata;
        pstrb   = v.strb;
        sel     = '0;
        rdy     = '0;
        rdata   = {v.data1, v.data0};
        @(posedge clk); #1;
        check({tag, " request"}, {31'd0, c_req},   32'd1);
        check({tag, " address"}, {16'd0, c_addr},  {16'd0, v.addr});
        check({tag, " write"},   {31'd0, c_write}, {31'd0, v.write});
        check({tag, " wdata"},   c_wdata,          v.wdata);
        check({tag, " strobe"},  {28'd0, c_strb},  {28'd0, (v.write ? v.strb : 4'hF)});
        penable = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            sel = v.sel;
            rdy = (n >= v.delay) ? v.sel : 2'b00;
            @(posedge clk); #1;
            n++;
            if (c_pready) got = 1'b1;
        end
        check({tag, " latency"}, n,                   v.exp_waits);
        check({tag, " prdata"},  c_prdata,            v.exp_rdata);
        check({tag, " pslverr"}, {31'd0, c_pslverr},  {31'd0, v.exp_err});
        check({tag, " req_low"}, {31'd0, c_req},      32'd0);
        $display("[TB] %s addr=0x%04h wr=%0d prdata=0x%08h pslverr=%0d waits=%0d",
                 tag, v.addr, v.write, c_prdata, c_pslverr, n);
        sel     = '0;
        rdy     = '0;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        check({tag, " pready_1cyc"}, {31'd0, c_pready}, 32'd0);
        check({tag, " prdata_idle"}, c_prdata,          32'd0);
        check({tag, " err_idle"},    {31'd0, c_pslverr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vb;
        //           wr    addr     wdata         strb  sel    dly data0         data1         exp_rdata     err  waits
        vecs[0] = '{1'b1, 16'h0010, 32'h0000_00A5, 4'hF, 2'b01, 0,  32'h1111_1111, 32'h2222_2222, 32'h0,        1'b0, 1};
        vecs[1] = '{1'b0, 16'h0014, 32'h5555_5555, 4'h3, 2'b10, 3,  32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[2] = '{1'b0, 16'h00F0, 32'h0,         4'h0, 2'b00, 0,  32'h1234_5678, 32'h8765_4321, 32'h0,        1'b1, 1};
        vecs[3] = '{1'b0, 16'h0020, 32'h0,         4'h0, 2'b11, 0,  32'hAAAA_0000, 32'h0000_BBBB, 32'h0,        1'b1, 1};
        vecs[4] = '{1'b0, 16'h0030, 32'h0,         4'h0, 2'b01, 99, 32'hFFFF_FFFF, 32'h0,         32'h0,        1'b1, 4};
        vecs[5] = '{1'b1, 16'h0040, 32'h1234_5678, 4'h5, 2'b10, 2,  32'h0,         32'h7777_7777, 32'h0,        1'b0, 3};
        vecs[6] = '{1'b0, 16'h0018, 32'h0,         4'h0, 2'b01, 0,  32'hCAFE_F00D, 32'h0BAD_0BAD, 32'hCAFE_F00D, 1'b0, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        use_b = 1'b0;
        check_all_zero("reset_a");
        use_b = 1'b1;
        check_all_zero("reset_b");
        $display("[TB] reset state checked");
        @(negedge clk);
        rst_n = 1'b1;
        use_b = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_xfer(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Unmapped read with error reporting disabled answers cleanly.
        vb = vecs[2];
        vb.exp_err = 1'b0;
        do_xfer(vb, 1'b1, "unmapped_noerr");
        do_xfer(vecs[6], 1'b1, "hit_noerr_dut");

        // Reset in the middle of REQUEST abandons the transfer.
        @(negedge clk);
        use_b = 1'b0; psel_a = 1'b1; penable = 1'b0;
        paddr = 16'h0050; pwrite = 1'b1; pwdata = 32'hA5A5_5A5A; pstrb = 4'h6;
        @(posedge clk); #1;
        penable = 1'b1; sel = 2'b01; rdy = 2'b00;
        @(posedge clk); #1;
        check("midreset pre_request", {31'd0, c_req}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        $display("[TB] mid-transfer reset checked");
        rst_n = 1'b1; psel_a = 1'b0; penable = 1'b0; sel = '0;
        @(posedge clk); #1;
        check("midreset no_pready", {31'd0, c_pready}, 32'd0);

        // psel dropped during REQUEST: request falls, no pready.
        @(negedge clk);
        psel_a = 1'b1; penable = 1'b0;
        paddr = 16'h0060; pwrite = 1'b0; pstrb = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1; sel = 2'b01; rdy = 2'b00;
        @(posedge clk); #1;
        check("abort pre_request", {31'd0, c_req}, 32'd1);
        psel_a = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("abort request_low", {31'd0, c_req},    32'd0);
        check("abort pready0",     {31'd0, c_pready}, 32'd0);
        sel = '0;
        @(posedge clk); #1;
        check("abort pready1",     {31'd0, c_pready}, 32'd0);
        $display("[TB] psel abort checked");
        do_xfer(vecs[6], 1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
